// File: rtl/ultrasonic_range_core_pkg.sv
// Shared types, defaults and constants for the ultrasonic range core.
// Holds the BCD payload struct, 7-segment patterns and BCD helper functions.
package ultrasonic_range_core_pkg;

    localparam int unsigned CYC_PER_TENTH_DEF = 145;
    localparam int unsigned SCAN_DIV_DEF      = 4096;
    localparam int unsigned STOP_CM_DEF       = 20;
    localparam int unsigned MIN_TENTHS_DEF    = 20;
    localparam int unsigned MAX_TENTHS_DEF    = 4000;

    localparam int unsigned CM_W     = 9;
    localparam int unsigned BCD_W    = 16;
    localparam int unsigned TENTHS_W = 14;
    localparam int unsigned SEG_W    = 7;

    localparam logic [CM_W-1:0] CM_MAX = 9'd511;

    // Active-low segment patterns, bit0 = a .. bit6 = g
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] HUND   = 2'd0;
    localparam logic [1:0] TENS   = 2'd1;
    localparam logic [1:0] UNITS  = 2'd2;
    localparam logic [1:0] TENTHS = 2'd3;

    typedef struct packed {
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] units;
        logic [3:0] tenths;
    } bcd_t;

    localparam bcd_t BCD_SAT = 16'h9999;

    // One-tenth increment with decimal carry; caller handles saturation.
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.tenths != 4'd9) begin
            r.tenths = v.tenths + 4'd1;
        end else begin
            r.tenths = 4'd0;
            if (v.units != 4'd9) begin
                r.units = v.units + 4'd1;
            end else begin
                r.units = 4'd0;
                if (v.tens != 4'd9) begin
                    r.tens = v.tens + 4'd1;
                end else begin
                    r.tens = 4'd0;
                    r.hund = v.hund + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [TENTHS_W-1:0] bcd_to_tenths(input bcd_t v);
        return TENTHS_W'(v.hund) * TENTHS_W'(1000) + TENTHS_W'(v.tens) * TENTHS_W'(100)
             + TENTHS_W'(v.units) * TENTHS_W'(10) + TENTHS_W'(v.tenths);
    endfunction

endpackage

// File: rtl/ultrasonic_range_core_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder; codes A-F blank.
module ultrasonic_range_core_seg7_decode
    import ultrasonic_range_core_pkg::*;
(
    input  logic [3:0]       bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ultrasonic_range_core.sv
// Echo pulse-width ranger: BCD/cm distance, multiplexed 4-digit display and
// two-motor obstacle/line-follower decision.
module ultrasonic_range_core
    import ultrasonic_range_core_pkg::*;
#(
    parameter int unsigned CYC_PER_TENTH = CYC_PER_TENTH_DEF,
    parameter int unsigned SCAN_DIV      = SCAN_DIV_DEF,
    parameter int unsigned STOP_CM       = STOP_CM_DEF,
    parameter int unsigned MIN_TENTHS    = MIN_TENTHS_DEF,
    parameter int unsigned MAX_TENTHS    = MAX_TENTHS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             echo,
    input  logic             line_l,
    input  logic             line_r,
    output logic [CM_W-1:0]  distance_cm,
    output logic [BCD_W-1:0] distance_bcd,
    output logic             in_range,
    output logic [3:0]       dig_sel,
    output logic [SEG_W-1:0] seg,
    output logic             dp,
    output logic             motor_l,
    output logic             motor_r
);

    localparam int unsigned PRE_W  = $clog2(CYC_PER_TENTH);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

    logic echo_s1_q, echo_s2_q, echo_d1_q;
    logic line_l_s1_q, line_l_s2_q, line_r_s1_q, line_r_s2_q;
    logic echo_rise_c, echo_fall_c;

    logic [PRE_W-1:0]    pre_q, pre_d;
    bcd_t                cnt_q, cnt_d;
    logic [CM_W-1:0]     cm_q, cm_d;
    logic                armed_q, armed_d;
    bcd_t                dist_bcd_q, dist_bcd_d;
    logic [CM_W-1:0]     dist_cm_q, dist_cm_d;
    logic                in_range_q, in_range_d;
    logic [TENTHS_W-1:0] tenths_c;

    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]          scan_idx_q, scan_idx_d;
    logic [3:0]          dig_sel_q, dig_sel_d;
    logic [SEG_W-1:0]    seg_q, seg_c;
    logic                dp_q, dp_d;
    logic [3:0]          digit_c;
    logic                motor_l_q, motor_l_d, motor_r_q, motor_r_d;

    // Sync chain keeps tracking through reset so a pulse in flight at release is not seen as a rise
    always_ff @(posedge clk) begin
        echo_s1_q   <= echo;
        echo_s2_q   <= echo_s1_q;
        echo_d1_q   <= echo_s2_q;
        line_l_s1_q <= line_l;
        line_l_s2_q <= line_l_s1_q;
        line_r_s1_q <= line_r;
        line_r_s2_q <= line_r_s1_q;
    end

    assign echo_rise_c = echo_s2_q & ~echo_d1_q;
    assign echo_fall_c = ~echo_s2_q & echo_d1_q;
    assign tenths_c    = bcd_to_tenths(cnt_q);

    // Pulse measurement; the rise cycle counts as the first elapsed cycle
    always_comb begin
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        cm_d       = cm_q;
        armed_d    = armed_q;
        dist_bcd_d = dist_bcd_q;
        dist_cm_d  = dist_cm_q;
        in_range_d = in_range_q;
        if (echo_rise_c) begin
            pre_d   = PRE_W'(1);
            cnt_d   = '0;
            cm_d    = '0;
            armed_d = 1'b1;
        end else if (echo_s2_q) begin
            if (pre_q == PRE_W'(CYC_PER_TENTH - 1)) begin
                pre_d = '0;
                if (cnt_q != BCD_SAT) begin
                    cnt_d = bcd_inc(cnt_q);
                    if (cnt_q.tenths == 4'd9 && cm_q != CM_MAX) begin
                        cm_d = cm_q + CM_W'(1);
                    end
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end else if (echo_fall_c && armed_q) begin
            dist_bcd_d = cnt_q;
            dist_cm_d  = cm_q;
            in_range_d = (tenths_c >= TENTHS_W'(MIN_TENTHS)) && (tenths_c <= TENTHS_W'(MAX_TENTHS));
            armed_d    = 1'b0;
        end
    end

    // Display scan; outputs follow the next-state index and value
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
        dig_sel_d = 4'b1000 >> scan_idx_d;
        dp_d      = in_range_d ? (scan_idx_d != UNITS) : (scan_idx_d != HUND);
        case (scan_idx_d)
            TENS:    digit_c = dist_bcd_d.tens;
            UNITS:   digit_c = dist_bcd_d.units;
            TENTHS:  digit_c = dist_bcd_d.tenths;
            default: digit_c = dist_bcd_d.hund;
        endcase
    end

    ultrasonic_range_core_seg7_decode u_seg7 (
        .bcd_i (digit_c),
        .seg_o (seg_c)
    );

    // Motor priority: obstacle, both lines, left line, right line, clear
    always_comb begin
        motor_l_d = 1'b1;
        motor_r_d = 1'b1;
        if (dist_cm_q < CM_W'(STOP_CM)) begin
            motor_l_d = 1'b0;
            motor_r_d = 1'b0;
        end else if (line_l_s2_q && line_r_s2_q) begin
            motor_l_d = 1'b0;
            motor_r_d = 1'b0;
        end else if (line_l_s2_q) begin
            motor_l_d = 1'b0;
        end else if (line_r_s2_q) begin
            motor_r_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q      <= '0;
            cnt_q      <= '0;
            cm_q       <= '0;
            armed_q    <= 1'b0;
            dist_bcd_q <= '0;
            dist_cm_q  <= '0;
            in_range_q <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= HUND;
            dig_sel_q  <= 4'b1000;
            seg_q      <= SEG_0;
            dp_q       <= 1'b1;
            motor_l_q  <= 1'b0;
            motor_r_q  <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            cm_q       <= cm_d;
            armed_q    <= armed_d;
            dist_bcd_q <= dist_bcd_d;
            dist_cm_q  <= dist_cm_d;
            in_range_q <= in_range_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            dig_sel_q  <= dig_sel_d;
            seg_q      <= seg_c;
            dp_q       <= dp_d;
            motor_l_q  <= motor_l_d;
            motor_r_q  <= motor_r_d;
        end
    end

    assign distance_cm  = dist_cm_q;
    assign distance_bcd = dist_bcd_q;
    assign in_range     = in_range_q;
    assign dig_sel      = dig_sel_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign motor_l      = motor_l_q;
    assign motor_r      = motor_r_q;

endmodule

// File: tb/tb_ultrasonic_range_core.sv
// Scoreboard bench for ultrasonic_range_core with a short prescaler and scan
// period so every scenario fits in a modest cycle budget.
module tb_ultrasonic_range_core;

    localparam int unsigned CYC  = 3;
    localparam int unsigned SCAN = 16;

    logic        clk = 1'b0;
    logic        rst_n, echo, line_l, line_r;
    logic [8:0]  distance_cm;
    logic [15:0] distance_bcd;
    logic        in_range, dp, motor_l, motor_r;
    logic [3:0]  dig_sel;
    logic [6:0]  seg;

    typedef struct {
        logic [15:0] bcd;
        logic [8:0]  cm;
        logic        rng;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ultrasonic_range_core #(
        .CYC_PER_TENTH (CYC),
        .SCAN_DIV      (SCAN),
        .STOP_CM       (20),
        .MIN_TENTHS    (20),
        .MAX_TENTHS    (4000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .echo         (echo),
        .line_l       (line_l),
        .line_r       (line_r),
        .distance_cm  (distance_cm),
        .distance_bcd (distance_bcd),
        .in_range     (in_range),
        .dig_sel      (dig_sel),
        .seg          (seg),
        .dp           (dp),
        .motor_l      (motor_l),
        .motor_r      (motor_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected measurement for an echo of w cycles
    function automatic exp_t model(input int w);
        int   n;
        exp_t e;
        n = w / CYC;
        if (n > 9999) n = 9999;
        e.bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
        e.cm  = (n / 10 > 511) ? 9'd511 : 9'(n / 10);
        e.rng = (n >= 20) && (n <= 4000);
        return e;
    endfunction

    // Returns {motor_l, motor_r}
    function automatic logic [1:0] motor_model(input logic [8:0] cm, input logic l, input logic r);
        if (cm < 9'd20) return 2'b00;
        if (l && r)     return 2'b00;
        if (l)          return 2'b01;
        if (r)          return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic measure(input int w, input string tag);
        exp_t e;
        exp_q.push_back(model(w));
        @(negedge clk);
        echo = 1'b1;
        repeat (w) @(negedge clk);
        echo = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_bcd_hold"}, 32'(distance_bcd), 32'(cur.bcd));
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, "_bcd"}, 32'(distance_bcd), 32'(e.bcd));
        check({tag, "_cm"}, 32'(distance_cm), 32'(e.cm));
        check({tag, "_rng"}, 32'(in_range), 32'(e.rng));
        check({tag, "_mot_hold"}, 32'({motor_l, motor_r}), 32'(motor_model(cur.cm, line_l, line_r)));
        cur = e;
        @(negedge clk);
        check({tag, "_mot"}, 32'({motor_l, motor_r}), 32'(motor_model(cur.cm, line_l, line_r)));
    endtask

    task automatic set_lines(input logic l, input logic r, input string tag);
        logic [1:0] old;
        old = motor_model(cur.cm, line_l, line_r);
        @(negedge clk);
        line_l = l;
        line_r = r;
        repeat (2) @(negedge clk);
        check({tag, "_hold"}, 32'({motor_l, motor_r}), 32'(old));
        @(negedge clk);
        check(tag, 32'({motor_l, motor_r}), 32'(motor_model(cur.cm, l, r)));
    endtask

    // Aligns to the start of the hundreds slot, then walks one full scan
    task automatic scan_check(input string tag);
        int          guard;
        logic [15:0] b;
        logic [3:0]  d;
        int          idx;
        guard = 0;
        while (dig_sel == 4'b1000 && guard < 8 * SCAN) begin
            @(negedge clk);
            guard++;
        end
        while (dig_sel != 4'b1000 && guard < 8 * SCAN) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_align"}, 32'(guard < 8 * SCAN), 32'd1);
        b = cur.bcd;
        for (int k = 0; k < 5; k++) begin
            idx = k % 4;
            d   = b[15 - 4 * idx -: 4];
            check($sformatf("%s_sel%0d", tag, k), 32'(dig_sel), 32'(4'b1000 >> idx));
            check($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(seg_of(d)));
            check($sformatf("%s_dp%0d", tag, k), 32'(dp), 32'(cur.rng ? (idx != 2) : (idx != 0)));
            if (k < 4) begin
                repeat (SCAN - 1) @(negedge clk);
                check($sformatf("%s_dwell%0d", tag, k), 32'(dig_sel), 32'(4'b1000 >> idx));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        echo   = 1'b0;
        line_l = 1'b0;
        line_r = 1'b0;
        cur.bcd = '0;
        cur.cm  = '0;
        cur.rng = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_bcd", 32'(distance_bcd), 32'h0000);
        check("rst_cm", 32'(distance_cm), 32'd0);
        check("rst_rng", 32'(in_range), 32'd0);
        check("rst_sel", 32'(dig_sel), 32'b1000);
        check("rst_seg", 32'(seg), 32'b1000000);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_mot", 32'({motor_l, motor_r}), 32'b00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        measure(CYC - 1, "short");
        measure(1234 * CYC, "nominal");
        measure(15 * CYC, "near15");
        measure(30 * CYC, "near30");
        measure(20 * CYC, "min20");
        measure(19 * CYC + 2, "min19");
        measure(199 * CYC, "stop199");
        measure(200 * CYC + 1, "stop200");
        measure(4000 * CYC, "max4000");
        measure(1234 * CYC + CYC - 1, "scan_val");
        scan_check("scan1234");
        measure(10005 * CYC, "sat");
        scan_check("scan_sat");

        measure(1000 * CYC, "cm100");
        set_lines(1'b1, 1'b0, "line10");
        set_lines(1'b0, 1'b1, "line01");
        set_lines(1'b1, 1'b1, "line11");
        set_lines(1'b0, 1'b0, "line00");

        // Reset in the middle of a pulse; the later fall must be ignored
        @(negedge clk);
        echo = 1'b1;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        echo = 1'b0;
        repeat (6) @(negedge clk);
        cur.bcd = '0;
        cur.cm  = '0;
        cur.rng = 1'b0;
        check("midrst_bcd", 32'(distance_bcd), 32'h0000);
        check("midrst_cm", 32'(distance_cm), 32'd0);
        check("midrst_rng", 32'(in_range), 32'd0);
        check("midrst_mot", 32'({motor_l, motor_r}), 32'b00);
        measure(567 * CYC + 1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
